seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode 7-segment display. Holds N BCD digits plus
//  per-digit decimal points in a double-buffered register, scans one digit per slot, inserts
//  anti-ghosting blanking between digits, and optionally blanks leading zeros. Sits between
//  datapath/counter logic (which issues load strobes) and the board-level seg/an pins.
// PARAMETERS
//  N_DIGITS   4      digits scanned, legal 2..8
//  DIV        50000  clocks per digit slot, legal >= BLANK_CYC+2
//  BLANK_CYC  16     clocks at slot start with all anodes off, legal 1..DIV-2
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  reset       in   1           synchronous, active-high
//  load        in   1           strobe: capture digits_in/dp_in into pending buffer
//  digits_in   in   4*N_DIGITS  BCD, digit i = [4i+3:4i], digit 0 least significant
//  dp_in       in   N_DIGITS    decimal point request per digit, 1 = lit
//  lz_blank    in   1           1 = suppress leading zeros
//  seg         out  7           segments {a,b,c,d,e,f,g} = seg[6:0], active-low, registered
//  dp          out  1           decimal point, active-low, registered
//  an          out  N_DIGITS    anode enables, active-low, one-hot-low or all-ones, registered
//  frame_tick  out  1           1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//  - One clock, clk; reset is synchronous and active-high.
//  - Reset values: seg=7'b1111111, dp=1, an=all 1, frame_tick=0; cnt=0, idx=0,
//    active buffer=all digits 0 / dp 0, pending flag=0. Reset mid-frame discards pending load.
//  - Prescaler cnt counts 0..DIV-1; on cnt==DIV-1, cnt->0 and idx advances, N_DIGITS-1 -> 0.
//  - frame_tick=1 on the cycle idx becomes 0 (registered with the idx update).
//  - Output stage: registered from the current (cnt, idx, active, lz_blank); 1-cycle latency.
//    cnt < BLANK_CYC: an=all 1, seg=7'h7F, dp=1.
//    otherwise: an[idx]=0, others 1; seg=decode(active digit idx); dp=~active_dp[idx].
//  - Decode: 0..9 -> 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,
//    0000000,0000100; codes 10..15 -> 1111111 (anode still driven).
//  - Leading-zero blank: digit i>0 shows seg=7'h7F when lz_blank=1 and digits N-1..i are all 0.
//    Digit 0 is never blanked. dp is independent of blanking.
//  - Double buffer: load=1 writes pending and sets pend. On the idx->0 transition, if pend,
//    active<=pending and pend clears. Load in that same cycle writes pending, keeps pend=1,
//    and is committed at the next frame boundary. Back-to-back loads: last one wins.
//  - No tearing: active never changes except at the idx->0 boundary.
//  - lz_blank is sampled live each cycle (not buffered).
// STRUCTURE
//  - Package seg7_pkg: SEG_BLANK=7'b1111111, SEG_DIGIT[0:9] pattern table, function
//    seg7_encode(logic [3:0]) returning 7-bit active-low pattern.
//  - Sub-module seg7_bcd_decode: combinational 4-bit -> 7-bit using seg7_pkg; one instance on
//    the muxed digit. Top holds prescaler, scan index, buffers, LZ mask, output registers.
//  - LZ mask computed combinationally from active buffer (prefix-AND of digit==0 from MSD).
// TESTING (N_DIGITS=4, DIV=8, BLANK_CYC=2)
//  1 Reset held 3 cycles -> an=4'b1111, seg=7'h7F, dp=1, frame_tick=0; after release an=4'b1110
//    first appears the edge after cnt==2; no load -> digit shows 0000001.
//  2 load digits_in=16'h1234, dp_in=4'b0100 -> next frame slots 0..3: seg=1001100, 0000110,
//    0010010, 1001111; dp=0 only while an=4'b1011; frame_tick every 32 cycles.
//  3 lz_blank=1, load 16'h0070 -> slots 3,2 seg=7'h7F with an active; slot1 0001111; slot0
//    0000001. load 16'h0000 -> only slot0 lit (0000001).
//  4 Anti-tear: load 16'h5678 during slot 1 -> slots 2,3 still old value; new value from
//    frame_tick; load asserted on the boundary cycle -> shown one frame later.
//  5 load 16'hFACB -> every slot seg=7'h7F with anodes still scanning.
//  6 Assert reset during slot 2 with pend=1 -> next edge reset values, pending discarded,
//    scan restarts at idx 0 displaying 0s.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the BCD-to-segment encoding (active-low, {a,b,c,d,e,f,g}).
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   // Codes 10..15 are not BCD and light nothing.
   function automatic logic [6:0] seg7_encode(input logic [3:0] code);
      logic [6:0] pattern;
      pattern = SEG_BLANK;
      if (code < 4'd10) begin
         pattern = SEG_DIGIT[code];
      end
      return pattern;
   endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD digit to active-low segment pattern.
module seg7_bcd_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   assign seg_o = seg7_encode(bcd_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode display driver with double-buffered digits,
// per-slot anti-ghosting blanking and optional leading-zero suppression.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  lz_blank,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_tick
);

   localparam int CNT_W = $clog2(DIV);
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    frame_tick_q, frame_tick_d;
   logic [4*N_DIGITS-1:0]   act_dig_q, act_dig_d;
   logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
   logic [4*N_DIGITS-1:0]   pend_dig_q, pend_dig_d;
   logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic                    pend_q, pend_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [N_DIGITS-1:0]     an_q, an_d;

   logic                    slot_end;
   logic                    frame_end;
   logic [N_DIGITS-1:0]     zero_run;
   logic [N_DIGITS-1:0]     lz_hide;
   logic [3:0]              cur_dig;
   logic [6:0]              dec_seg;

   // zero_run[i]: digits N-1 down to i are all zero in the active buffer.
   always_comb begin
      zero_run = '0;
      zero_run[N_DIGITS-1] = (act_dig_q[4*(N_DIGITS-1) +: 4] == 4'd0);
      for (int i = N_DIGITS - 2; i >= 0; i--) begin
         zero_run[i] = zero_run[i+1] && (act_dig_q[4*i +: 4] == 4'd0);
      end
      lz_hide = '0;
      if (lz_blank) begin
         lz_hide = zero_run;
         lz_hide[0] = 1'b0;
      end
   end

   assign cur_dig = act_dig_q[{idx_q, 2'b00} +: 4];

   seg7_bcd_decode u_decode (
      .bcd_i (cur_dig),
      .seg_o (dec_seg)
   );

   always_comb begin
      slot_end  = (cnt_q == CNT_LAST);
      frame_end = slot_end && (idx_q == IDX_LAST);

      cnt_d = slot_end ? '0 : cnt_q + CNT_ONE;
      idx_d = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
      end
      frame_tick_d = frame_end;

      // Active buffer only changes at the frame boundary, so a frame never tears.
      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_d     = pend_q;
      if (frame_end && pend_q) begin
         act_dig_d = pend_dig_q;
         act_dp_d  = pend_dp_q;
         pend_d    = 1'b0;
      end
      if (load) begin
         pend_dig_d = digits_in;
         pend_dp_d  = dp_in;
         pend_d     = 1'b1;
      end

      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (cnt_q >= BLANK_END) begin
         an_d[idx_q] = 1'b0;
         seg_d       = lz_hide[idx_q] ? SEG_BLANK : dec_seg;
         dp_d        = ~act_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         frame_tick_q <= 1'b0;
         act_dig_q    <= '0;
         act_dp_q     <= '0;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
         pend_q       <= 1'b0;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         an_q         <= '1;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_tick_q <= frame_tick_d;
         act_dig_q    <= act_dig_d;
         act_dp_q     <= act_dp_d;
         pend_dig_q   <= pend_dig_d;
         pend_dp_q    <= pend_dp_d;
         pend_q       <= pend_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (N_DIGITS=4, DIV=8, BLANK_CYC=2); one expected
// {an,seg,dp} entry is queued per lit slot and checked as each slot lights up.
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int FR = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic        lz_blank = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   always #5 clk = ~clk;

   seg7_scan_driver #(.N_DIGITS(N), .DIV(8), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   logic [11:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   logic [15:0] act_m = '0;
   logic [3:0]  act_dp_m = '0;
   logic [15:0] pend_m = '0;
   logic [3:0]  pend_dp_m = '0;
   bit          pend_v = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic push_frame(input bit lz);
      bit         zr;
      bit [3:0]   hide;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      zr   = 1'b1;
      hide = '0;
      for (int i = N - 1; i >= 1; i--) begin
         zr      = zr && (act_m[4*i +: 4] == 4'd0);
         hide[i] = lz && zr;
      end
      for (int i = 0; i < N; i++) begin
         an_e  = ~(4'b0001 << i);
         seg_e = hide[i] ? 7'h7F : exp_seg(act_m[4*i +: 4]);
         exp_q.push_back({an_e, seg_e, ~act_dp_m[i]});
      end
   endtask

   // Monitor: a new lit slot is any non-blank an that differs from the previous sample.
   logic [3:0] prev_an = 4'hF;
   always @(negedge clk) begin
      logic [11:0] e;
      if (reset) begin
         prev_an = 4'hF;
      end else begin
         if (an != 4'hF && an != prev_an) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_slot: got %h expected none", {an, seg, dp});
            end else begin
               e = exp_q.pop_front();
               check("slot", {20'd0, an, seg, dp}, {20'd0, e});
            end
         end
         prev_an = an;
      end
   end

   task automatic check_reset_vals();
      check("rst_an", {28'd0, an}, 32'h0000000F);
      check("rst_seg", {25'd0, seg}, 32'h0000007F);
      check("rst_dp", {31'd0, dp}, 32'd1);
      check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
   endtask

   // Called on the negedge where cnt=0, idx=0; returns on the next such negedge.
   task automatic run_frame(input bit first, input bit lz,
                            input int c1, input logic [15:0] d1, input logic [3:0] p1,
                            input int c2, input logic [15:0] d2, input logic [3:0] p2,
                            input int rst_cyc);
      int ft_bad;
      lz_blank = lz;
      check("frame_tick_start", {31'd0, frame_tick}, first ? 32'd0 : 32'd1);
      push_frame(lz);
      ft_bad = 0;
      for (int c = 0; c < FR; c++) begin
         if (c == FR - 1 && pend_v) begin
            act_m    = pend_m;
            act_dp_m = pend_dp_m;
            pend_v   = 1'b0;
         end
         load = 1'b0;
         if (c == c1) begin
            load = 1'b1; digits_in = d1; dp_in = p1;
            pend_m = d1; pend_dp_m = p1; pend_v = 1'b1;
         end else if (c == c2) begin
            load = 1'b1; digits_in = d2; dp_in = p2;
            pend_m = d2; pend_dp_m = p2; pend_v = 1'b1;
         end
         if (c > 0 && frame_tick) ft_bad++;
         if (c == 2) check("an_blank_c2", {28'd0, an}, 32'h0000000F);
         if (c == 3) check("an_slot0_c3", {28'd0, an}, 32'h0000000E);
         if (c == rst_cyc) begin
            reset = 1'b1;
            load  = 1'b0;
            @(negedge clk);
            check_reset_vals();
            exp_q.delete();
            act_m = '0; act_dp_m = '0; pend_v = 1'b0;
            reset = 1'b0;
            return;
         end
         @(negedge clk);
      end
      load = 1'b0;
      check("frame_tick_quiet", ft_bad, 0);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      reset = 1'b0;

      // first, lz, load1(cyc,digits,dp), load2(cyc,digits,dp), reset cycle
      run_frame(1, 0,  5, 16'h1234, 4'b0100, -1, 16'h0, 4'h0, -1);
      run_frame(0, 0, 10, 16'h0070, 4'b0000, -1, 16'h0, 4'h0, -1);
      run_frame(0, 1,  3, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1);
      run_frame(0, 1, 12, 16'h5678, 4'b0000, -1, 16'h0, 4'h0, -1);
      run_frame(0, 0, 31, 16'h9999, 4'b0001, -1, 16'h0, 4'h0, -1);
      run_frame(0, 0, -1, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1);
      run_frame(0, 0,  7, 16'hFACB, 4'b0000, -1, 16'h0, 4'h0, -1);
      run_frame(0, 0,  4, 16'h0001, 4'b0000,  5, 16'h0310, 4'b1000, -1);
      run_frame(0, 1, -1, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1);
      run_frame(0, 0,  3, 16'h1234, 4'b1111, -1, 16'h0, 4'h0, 21);
      run_frame(1, 0, -1, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1);
      run_frame(0, 0, -1, 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1);

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
